pe_vec_mac: RTL and testbench
=============================

PE_VEC_MAC -- requirements
Module: pe_vec_mac

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel MAC lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, activation width per lane.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, weight width per lane.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, accumulator width per lane.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port signed_mode  in  1  1 = signed operands, 0 = unsigned; sampled on first beat of a vector.
REQ-008 SHALL have port w_load  in  1  write w_data into shadow weight bank.
REQ-009 SHALL have port w_data  in  LANES*WEIGHT_WIDTH  per-lane weights, lane 0 in LSBs.
REQ-010 SHALL have port w_swap  in  1  request copy of shadow bank into active bank.
REQ-011 SHALL have port in_valid  in  1  activation beat valid.
REQ-012 SHALL have port in_ready  out  1  beat accepted when in_valid and in_ready are both high.
REQ-013 SHALL have port in_data  in  LANES*DATA_WIDTH  per-lane activations.
REQ-014 SHALL have port in_last  in  1  marks last beat of a dot-product vector.
REQ-015 SHALL have port fwd_valid  out  1  one-cycle pulse per accepted beat.
REQ-016 SHALL have port fwd_data  out  LANES*DATA_WIDTH  registered copy of accepted in_data, for systolic forwarding.
REQ-017 SHALL have port out_valid  out  1  result valid.
REQ-018 SHALL have port out_ready  in  1  result consumed when out_valid and out_ready are both high.
REQ-019 SHALL have port out_acc  out  LANES*ACC_WIDTH  per-lane results.
REQ-020 SHALL have port out_sat  out  LANES  per-lane sticky saturation flag for the vector.

Function
REQ-021 SHALL implement FSM states IDLE (accumulators empty), ACCUM (partial sum held) and HOLD (result pending).
REQ-022 SHALL drive in_ready = (state != HOLD).
REQ-023 SHALL add, per accepted beat in each lane, data*active_weight to the lane accumulator; on the first beat of a vector the accumulator and out_sat are first cleared.
REQ-024 SHALL, in signed mode, sign-extend operands; in unsigned mode, zero-extend them. The accumulator is always interpreted as signed.
REQ-025 SHALL form each sum at ACC_WIDTH+1 bits and clamp it to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp sets that lane's sticky sat bit.
REQ-026 SHALL use the following transitions: IDLE->ACCUM on an accepted non-last beat; IDLE/ACCUM->HOLD on an accepted last beat; ACCUM->ACCUM on an accepted non-last beat; HOLD->IDLE on out_ready (out_valid drops and in_ready rises the next cycle).
REQ-027 SHALL assert out_valid in the cycle after the in_last beat is accepted (latency 1); out_acc/out_sat hold stable while out_valid=1.
REQ-028 SHALL register fwd_data on every accepted beat and pulse fwd_valid for 1 cycle; fwd_data holds otherwise.
REQ-029 SHALL load w_data into the shadow bank on w_load in any state.
REQ-030 SHALL apply w_swap immediately when in IDLE with no beat accepted that cycle. Otherwise it becomes a pending swap, applied at the edge that accepts the next in_last beat or, if in HOLD, at the HOLD->IDLE edge. A vector is never split across weight banks.
REQ-031 SHALL, on simultaneous w_load and swap application, copy the old shadow to active and write w_data to shadow.
REQ-032 SHALL make a beat accepted in the same cycle as a swap use the pre-swap active weights.
REQ-033 SHALL ignore in_valid while in HOLD; no data is lost because in_ready=0.

Reset
REQ-034 SHALL, on rst, clear to 0: state (IDLE), accumulators, both weight banks, pending swap, in_ready→1 next cycle, fwd_valid, fwd_data, out_valid, out_acc, out_sat.
REQ-035 SHALL, when rst is asserted mid-vector or in HOLD, discard the partial or pending result; no out_valid follows.

Structure
REQ-036 SHALL place the FSM state enum and the saturation min/max constant functions in shared package pe_pkg.
REQ-037 SHALL instantiate LANES copies of sub-module pe_lane (one lane: multiply, extend, saturating accumulate, sticky flag); the FSM, weight banks and handshakes live in pe_vec_mac.

Verification
REQ-038 SHALL verify: weights 5 loaded and swapped in IDLE; lane0 data 3, 4, -2 (last on -2) -> out_acc lane0 = 25, out_valid 1 cycle after last accept, out_sat = 0.
REQ-039 SHALL verify: out_ready held 0 for 5 cycles after a result -> out_valid stays 1, out_acc stable, in_ready = 0; out_ready = 1 -> in_ready = 1 the next cycle.
REQ-040 SHALL verify, with ACC_WIDTH = 16 and weight 127: data 127 x 3 beats -> 32767 with sat = 1; data -128 x 3 beats -> -32768 with sat = 1.
REQ-041 SHALL verify: unsigned mode, data 200, weight 200, single last beat -> 40000 (ACC_WIDTH = 32), sat = 0.
REQ-042 SHALL verify: active = 2, shadow = 3, w_swap between beats of vector {1, 1(last)} -> result 2+2 = 4; next vector {1(last)} -> 3.
REQ-043 SHALL verify: rst pulse after 2 beats of a vector -> all outputs 0, no out_valid; after reload of weight 4, vector {2(last)} -> 8.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and saturation helpers for the vector MAC processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } pe_state_e;

    // Largest value a signed accumulator of acc_w bits can hold, 65-bit wide.
    function automatic logic signed [64:0] sat_max(input int acc_w);
        sat_max = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    endfunction

    // Smallest value a signed accumulator of acc_w bits can hold, 65-bit wide.
    function automatic logic signed [64:0] sat_min(input int acc_w);
        sat_min = -(65'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/pe_lane.sv
// One MAC lane: operand extension, multiply, saturating accumulate, sticky flag.
module pe_lane
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_en,
    input  logic                    first_beat,
    input  logic                    signed_mode,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    output logic [ACC_WIDTH-1:0]    acc,
    output logic                    sat
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 2;
    // Sum is kept wide enough that neither the product nor the add can wrap
    // before the clamp compare.
    localparam int SUM_W  = (ACC_WIDTH + 1 > PROD_W + 1) ? ACC_WIDTH + 1 : PROD_W + 1;

    localparam logic signed [64:0]      MAX_FULL = sat_max(ACC_WIDTH);
    localparam logic signed [64:0]      MIN_FULL = sat_min(ACC_WIDTH);
    localparam logic signed [SUM_W-1:0] MAX_S    = MAX_FULL[SUM_W-1:0];
    localparam logic signed [SUM_W-1:0] MIN_S    = MIN_FULL[SUM_W-1:0];

    logic signed [DATA_WIDTH:0]   data_x;
    logic signed [WEIGHT_WIDTH:0] weight_x;
    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      base;
    logic signed [SUM_W-1:0]      sum;
    logic [ACC_WIDTH-1:0]         acc_q, acc_d;
    logic                         sat_q, sat_d;

    // Extend, multiply, add and clamp the next accumulator value
    always_comb begin
        data_x   = {signed_mode & data[DATA_WIDTH-1], data};
        weight_x = {signed_mode & weight[WEIGHT_WIDTH-1], weight};
        prod     = data_x * weight_x;
        if (first_beat) begin
            base = '0;
        end else begin
            base = SUM_W'($signed(acc_q));
        end
        sum   = base + SUM_W'(prod);
        acc_d = acc_q;
        sat_d = sat_q;
        if (beat_en) begin
            sat_d = first_beat ? 1'b0 : sat_q;
            if (sum > MAX_S) begin
                acc_d = MAX_S[ACC_WIDTH-1:0];
                sat_d = 1'b1;
            end else if (sum < MIN_S) begin
                acc_d = MIN_S[ACC_WIDTH-1:0];
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
        end
    end

    // Accumulator and sticky saturation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

// File: rtl/pe_vec_mac.sv
// Vector MAC processing element: LANES parallel dot-product lanes with
// double-buffered weights, input/output handshakes and systolic forwarding.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | accumulators empty, next beat starts a vector
//   ST_ACCUM | partial sum held, vector in progress
//   ST_HOLD  | result pending on out_acc until out_ready
module pe_vec_mac
    import pe_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          signed_mode,
    input  logic                          w_load,
    input  logic [LANES*WEIGHT_WIDTH-1:0] w_data,
    input  logic                          w_swap,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          fwd_valid,
    output logic [LANES*DATA_WIDTH-1:0]   fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    out_acc,
    output logic [LANES-1:0]              out_sat
);

    pe_state_e                     state_q, state_d;
    logic                          mode_q, mode_d;
    logic [LANES*WEIGHT_WIDTH-1:0] w_act_q, w_act_d;
    logic [LANES*WEIGHT_WIDTH-1:0] w_sh_q, w_sh_d;
    logic                          swap_pend_q, swap_pend_d;
    logic                          fwd_valid_q, fwd_valid_d;
    logic [LANES*DATA_WIDTH-1:0]   fwd_data_q, fwd_data_d;
    logic                          beat_acc, first_beat, lane_mode;
    logic                          swap_req, swap_apply;

    assign in_ready   = (state_q != ST_HOLD);
    assign out_valid  = (state_q == ST_HOLD);
    assign beat_acc   = in_valid && in_ready;
    assign first_beat = beat_acc && (state_q == ST_IDLE);
    assign lane_mode  = first_beat ? signed_mode : mode_q;

    // Next-state logic for the vector sequencing FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (beat_acc) state_d = in_last ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (beat_acc && in_last) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight banks: a swap only lands on a vector boundary so a vector never
    // mixes banks; the beat accepted on that edge still sees the old weights.
    always_comb begin
        swap_req    = w_swap || swap_pend_q;
        swap_apply  = swap_req && (((state_q == ST_IDLE) && !beat_acc) ||
                                   (beat_acc && in_last) ||
                                   ((state_q == ST_HOLD) && out_ready));
        w_act_d     = swap_apply ? w_sh_q : w_act_q;
        w_sh_d      = w_load ? w_data : w_sh_q;
        swap_pend_d = swap_req && !swap_apply;
    end

    // Operand mode latch and systolic forwarding register
    always_comb begin
        mode_d      = lane_mode;
        fwd_valid_d = beat_acc;
        fwd_data_d  = beat_acc ? in_data : fwd_data_q;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            w_act_q     <= '0;
            w_sh_q      <= '0;
            swap_pend_q <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            w_act_q     <= w_act_d;
            w_sh_q      <= w_sh_d;
            swap_pend_q <= swap_pend_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .beat_en    (beat_acc),
            .first_beat (first_beat),
            .signed_mode(lane_mode),
            .data       (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .weight     (w_act_q[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .acc        (out_acc[g*ACC_WIDTH +: ACC_WIDTH]),
            .sat        (out_sat[g])
        );
    end

endmodule

// File: tb/tb_pe_vec_mac.sv
// Bench for pe_vec_mac: two instances (32-bit and 16-bit accumulators) share
// stimulus; a cycle-level behavioural model is compared every cycle, and
// hand-computed values pin the key results.
module tb_pe_vec_mac;

    localparam int L  = 4;
    localparam int DW = 8;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst, signed_mode, w_load, w_swap, in_valid, in_last, out_ready;
    logic [L*WW-1:0] w_data;
    logic [L*DW-1:0] in_data;

    logic            r32_in_ready, r32_fwd_valid, r32_out_valid;
    logic [L*DW-1:0] r32_fwd_data;
    logic [L*32-1:0] r32_out_acc;
    logic [L-1:0]    r32_out_sat;
    logic            r16_in_ready, r16_fwd_valid, r16_out_valid;
    logic [L*DW-1:0] r16_fwd_data;
    logic [L*16-1:0] r16_out_acc;
    logic [L-1:0]    r16_out_sat;

    int errors = 0;
    int checks = 0;

    pe_vec_mac #(.LANES(L), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .w_load(w_load), .w_data(w_data),
        .w_swap(w_swap), .in_valid(in_valid), .in_ready(r32_in_ready), .in_data(in_data),
        .in_last(in_last), .fwd_valid(r32_fwd_valid), .fwd_data(r32_fwd_data),
        .out_valid(r32_out_valid), .out_ready(out_ready), .out_acc(r32_out_acc),
        .out_sat(r32_out_sat));

    pe_vec_mac #(.LANES(L), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .w_load(w_load), .w_data(w_data),
        .w_swap(w_swap), .in_valid(in_valid), .in_ready(r16_in_ready), .in_data(in_data),
        .in_last(in_last), .fwd_valid(r16_fwd_valid), .fwd_data(r16_fwd_data),
        .out_valid(r16_out_valid), .out_ready(out_ready), .out_acc(r16_out_acc),
        .out_sat(r16_out_sat));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_hold, m_invec, m_pend, m_mode, m_fv, started;
    logic [31:0] m_fd;
    logic [7:0]  m_act [L];
    logic [7:0]  m_sh  [L];
    longint      m_acc32 [L];
    longint      m_acc16 [L];
    bit          m_sat32 [L];
    bit          m_sat16 [L];
    bit          mm_ok, mm_req, mm_swap, mm_hit;
    longint      mm_p;

    function automatic longint ext8(input logic [7:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'({56'd0, v});
    endfunction

    function automatic longint clampw(input longint v, input int w, output bit hit);
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -(longint'(1) <<< (w - 1));
        hit = 1'b0;
        if (v > hi) begin hit = 1'b1; return hi; end
        if (v < lo) begin hit = 1'b1; return lo; end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_hold = 0; m_invec = 0; m_pend = 0; m_mode = 0; m_fv = 0; m_fd = '0;
            for (int i = 0; i < L; i++) begin
                m_act[i] = '0; m_sh[i] = '0;
                m_acc32[i] = 0; m_acc16[i] = 0; m_sat32[i] = 0; m_sat16[i] = 0;
            end
        end else begin
            mm_ok   = in_valid && !m_hold;
            mm_req  = w_swap || m_pend;
            mm_swap = mm_req && ((!m_invec && !m_hold && !mm_ok) || (mm_ok && in_last) ||
                                 (m_hold && out_ready));
            if (mm_ok) begin
                if (!m_invec) begin
                    m_mode = signed_mode;
                    for (int i = 0; i < L; i++) begin
                        m_acc32[i] = 0; m_acc16[i] = 0; m_sat32[i] = 0; m_sat16[i] = 0;
                    end
                end
                for (int i = 0; i < L; i++) begin
                    mm_p = ext8(in_data[i*DW +: DW], m_mode) * ext8(m_act[i], m_mode);
                    m_acc32[i] = clampw(m_acc32[i] + mm_p, 32, mm_hit);
                    m_sat32[i] = m_sat32[i] | mm_hit;
                    m_acc16[i] = clampw(m_acc16[i] + mm_p, 16, mm_hit);
                    m_sat16[i] = m_sat16[i] | mm_hit;
                end
                m_invec = !in_last;
                m_hold  = in_last;
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
            end
            m_fv = mm_ok;
            if (mm_ok) m_fd = in_data;
            m_pend = mm_req && !mm_swap;
            for (int i = 0; i < L; i++) begin
                if (mm_swap) m_act[i] = m_sh[i];
                if (w_load)  m_sh[i]  = w_data[i*WW +: WW];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready32",  64'(r32_in_ready),  64'(!m_hold));
            chk("out_valid32", 64'(r32_out_valid), 64'(m_hold));
            chk("fwd_valid32", 64'(r32_fwd_valid), 64'(m_fv));
            chk("fwd_data32",  64'(r32_fwd_data),  64'(m_fd));
            chk("in_ready16",  64'(r16_in_ready),  64'(!m_hold));
            chk("out_valid16", 64'(r16_out_valid), 64'(m_hold));
            chk("fwd_valid16", 64'(r16_fwd_valid), 64'(m_fv));
            chk("fwd_data16",  64'(r16_fwd_data),  64'(m_fd));
            for (int i = 0; i < L; i++) begin
                chk($sformatf("acc32_l%0d", i), 64'(r32_out_acc[i*32 +: 32]), 64'(m_acc32[i][31:0]));
                chk($sformatf("sat32_l%0d", i), 64'(r32_out_sat[i]), 64'(m_sat32[i]));
                chk($sformatf("acc16_l%0d", i), 64'(r16_out_acc[i*16 +: 16]), 64'(m_acc16[i][15:0]));
                chk($sformatf("sat16_l%0d", i), 64'(r16_out_sat[i]), 64'(m_sat16[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        w_load   = 1'b0;
        w_swap   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
    endtask

    task automatic load(input logic [7:0] w, input logic swap);
        w_load = 1'b1;
        w_data = {4{w}};
        w_swap = swap;
        cyc();
    endtask

    task automatic swap_only();
        w_swap = 1'b1;
        cyc();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("consume_in_ready", 64'(r32_in_ready), 64'd1);
        chk("consume_out_valid", 64'(r32_out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; signed_mode = 1'b1; w_load = 0; w_swap = 0; w_data = '0;
        in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
        repeat (2) cyc();
        chk("rst_in_ready", 64'(r32_in_ready), 64'd1);
        chk("rst_out_valid", 64'(r32_out_valid), 64'd0);
        chk("rst_out_acc", 64'(r32_out_acc[63:0]), 64'd0);
        chk("rst_fwd_valid", 64'(r32_fwd_valid), 64'd0);
        rst = 1'b0;
        cyc();

        // weight 5, vector lane0 {3,4,-2}
        load(8'd5, 1'b0);
        swap_only();
        beat({8'd0, 8'hFD, 8'd10, 8'd3}, 1'b0);
        beat({8'd0, 8'd0,  8'd0,  8'd4}, 1'b0);
        beat({8'd1, 8'd0,  8'd0,  8'hFE}, 1'b1);
        chk("lat_out_valid", 64'(r32_out_valid), 64'd1);
        chk("v1_acc_l0", 64'(r32_out_acc[31:0]), 64'd25);
        chk("v1_acc_l1", 64'(r32_out_acc[63:32]), 64'd50);
        chk("v1_acc_l2", 64'(r32_out_acc[95:64]), 64'(32'hFFFFFFF1));
        chk("v1_sat", 64'(r32_out_sat), 64'd0);
        chk("v1_fwd", 64'(r32_fwd_data), 64'(32'h010000FE));

        // back-pressure: five cycles with out_ready low, beats offered and ignored
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h77777777; in_last = 1'b1;
            cyc();
            chk("hold_out_valid", 64'(r32_out_valid), 64'd1);
            chk("hold_in_ready", 64'(r32_in_ready), 64'd0);
            chk("hold_acc_l0", 64'(r32_out_acc[31:0]), 64'd25);
        end
        consume();

        // saturation with weight 127
        load(8'd127, 1'b0);
        swap_only();
        repeat (2) beat({4{8'd127}}, 1'b0);
        beat({4{8'd127}}, 1'b1);
        chk("pos16_acc", 64'(r16_out_acc[15:0]), 64'(16'h7FFF));
        chk("pos16_sat", 64'(r16_out_sat[0]), 64'd1);
        chk("pos32_acc", 64'(r32_out_acc[31:0]), 64'd48387);
        chk("pos32_sat", 64'(r32_out_sat[0]), 64'd0);
        consume();
        repeat (2) beat({4{8'h80}}, 1'b0);
        beat({4{8'h80}}, 1'b1);
        chk("neg16_acc", 64'(r16_out_acc[15:0]), 64'(16'h8000));
        chk("neg16_sat", 64'(r16_out_sat[0]), 64'd1);
        chk("neg32_acc", 64'(r32_out_acc[31:0]), 64'(32'hFFFF4180));
        consume();

        // unsigned 200 x 200
        load(8'd200, 1'b0);
        swap_only();
        signed_mode = 1'b0;
        beat({4{8'd200}}, 1'b1);
        signed_mode = 1'b1;
        chk("uns32_acc", 64'(r32_out_acc[31:0]), 64'd40000);
        chk("uns32_sat", 64'(r32_out_sat[0]), 64'd0);
        consume();

        // swap requested mid-vector is deferred to the last beat
        load(8'd2, 1'b0);
        swap_only();
        load(8'd3, 1'b0);
        beat({4{8'd1}}, 1'b0);
        swap_only();
        beat({4{8'd1}}, 1'b1);
        chk("midswap_acc", 64'(r32_out_acc[31:0]), 64'd4);
        consume();
        beat({4{8'd1}}, 1'b1);
        chk("postswap_acc", 64'(r32_out_acc[31:0]), 64'd3);
        // swap requested while holding lands on the HOLD->IDLE edge
        load(8'd6, 1'b0);
        swap_only();
        consume();
        beat({4{8'd1}}, 1'b1);
        chk("holdswap_acc", 64'(r32_out_acc[31:0]), 64'd6);
        consume();

        // reset mid-vector discards the partial sum
        beat({4{8'd7}}, 1'b0);
        beat({4{8'd7}}, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_acc", 64'(r32_out_acc[31:0]), 64'd0);
        chk("mrst_fwd", 64'(r32_fwd_data), 64'd0);
        chk("mrst_in_ready", 64'(r32_in_ready), 64'd1);
        repeat (3) begin
            cyc();
            chk("mrst_no_valid", 64'(r32_out_valid), 64'd0);
        end
        load(8'd4, 1'b0);
        load(8'd9, 1'b1);
        beat({4{8'd2}}, 1'b1);
        chk("reload_acc", 64'(r32_out_acc[31:0]), 64'd8);
        consume();
        swap_only();
        beat({4{8'd2}}, 1'b1);
        chk("ldswap_acc", 64'(r32_out_acc[31:0]), 64'd18);
        consume();

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
